dwt_multilevel_core: RTL and testbench

Parametrised multi-level discrete wavelet transform engine, the successor of the fixed-configuration wavelet core. It computes low-pass (approximation) and high-pass (detail) coefficients over a CPU-loaded sample buffer for a configurable number of levels. It writes each level's approximations back in place for the next level and streams all coefficients out over a valid/ready port. It sits behind the CPU-bus address decoder, like the existing core.

---
 rtl/dwt_pkg.sv | 20 ++
 rtl/dwt_mac_unit.sv | 45 ++++
 rtl/dwt_multilevel_core.sv | 161 ++++++++++++++++
 tb/tb_dwt_multilevel_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// dwt_pkg: state encoding, width helpers and result saturation shared by the DWT core.
package dwt_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_ERR, S_MAC, S_EMIT_D, S_EMIT_A, S_WB, S_NEXT, S_DONE
    } state_t;

    function automatic int acc_width(input int dw, input int cw, input int mf);
        return dw + cw + $clog2(mf);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int dw);
        logic signed [127:0] mx;
        mx = (128'sd1 <<< (dw - 1)) - 128'sd1;
        return v > mx ? mx : (v < -mx - 128'sd1) ? -mx - 128'sd1 : v;
    endfunction
endpackage

// File: rtl/dwt_mac_unit.sv
// dwt_mac_unit: paired low/high-pass multiply-accumulate with fixed-point rescaling.
// DWT_CORE_SAT_EN saturates the rescaled result; without it the result wraps.
module dwt_mac_unit
    import dwt_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int COEF_WIDTH      = 16,
    parameter int COEF_FRAC       = 14,
    parameter int MAX_FILTER_SIZE = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [COEF_WIDTH-1:0] lo_i,
    input  logic signed [COEF_WIDTH-1:0] hi_i,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic signed [DATA_WIDTH-1:0] d_o
);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int AW = acc_width(DATA_WIDTH, COEF_WIDTH, MAX_FILTER_SIZE);
    logic signed [PW-1:0] p_lo, p_hi;
    logic signed [AW-1:0] acc_lo_q, acc_hi_q, sh_lo, sh_hi;
    assign p_lo = PW'(x_i) * PW'(lo_i);
    assign p_hi = PW'(x_i) * PW'(hi_i);
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            acc_lo_q <= '0;
            acc_hi_q <= '0;
        end else if (en_i) begin
            acc_lo_q <= acc_lo_q + AW'(p_lo);
            acc_hi_q <= acc_hi_q + AW'(p_hi);
        end
    end
    assign sh_lo = acc_lo_q >>> COEF_FRAC;
    assign sh_hi = acc_hi_q >>> COEF_FRAC;
`ifdef DWT_CORE_SAT_EN
    assign a_o = DATA_WIDTH'(saturate(128'(sh_lo), DATA_WIDTH));
    assign d_o = DATA_WIDTH'(saturate(128'(sh_hi), DATA_WIDTH));
`else
    assign a_o = DATA_WIDTH'(sh_lo);
    assign d_o = DATA_WIDTH'(sh_hi);
`endif
endmodule

// File: rtl/dwt_multilevel_core.sv
// dwt_multilevel_core: multi-level DWT over a CPU-loaded buffer, streaming coefficients out.
// Optional DWT_CORE_SAT_EN selects saturating result reduction in the MAC unit.
module dwt_multilevel_core
    import dwt_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int COEF_WIDTH      = 16,
    parameter int COEF_FRAC       = 14,
    parameter int MAX_FILTER_SIZE = 32,
    parameter int MAX_LEN_LOG2    = 11,
    parameter int MAX_LEVELS      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sample_wr_en,
    input  logic [MAX_LEN_LOG2-1:0]               sample_wr_addr,
    input  logic [DATA_WIDTH-1:0]                 sample_wr_data,
    input  logic                                  coef_wr_en,
    input  logic                                  coef_wr_hi,
    input  logic [$clog2(MAX_FILTER_SIZE)-1:0]    coef_wr_idx,
    input  logic [COEF_WIDTH-1:0]                 coef_wr_data,
    input  logic [$clog2(MAX_FILTER_SIZE+1)-1:0]  cfg_filter_size,
    input  logic [$clog2(MAX_LEVELS+1)-1:0]       cfg_levels,
    input  logic [$clog2(MAX_LEN_LOG2+1)-1:0]     cfg_len_log2,
    input  logic                                  go,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_detail,
    output logic [$clog2(MAX_LEVELS)-1:0]         out_level,
    output logic [MAX_LEN_LOG2-1:0]               out_index
);
    localparam int IW = $clog2(MAX_FILTER_SIZE);
    localparam int FW = cnt_width(MAX_FILTER_SIZE);
    localparam int LW = cnt_width(MAX_LEVELS);
    localparam int NW = cnt_width(MAX_LEN_LOG2);
    localparam int AW = MAX_LEN_LOG2;
    localparam int OW = $clog2(MAX_LEVELS);

    state_t state_q, state_d;
    logic [FW-1:0] f_q, c_q, c_d;
    logic [LW-1:0] lv_q, lvl_q, lvl_d;
    logic [NW-1:0] ln_q;
    logic [AW-1:0] k_q, k_d, ml1, ram_wa;
    logic [AW:0] nl;
    logic [AW+1:0] addr;
    logic [IW-1:0] tap_q;
    logic err_q, pad_q, cfg_ok, last_k, last_lvl, idle_wr, ram_we;
    logic signed [DATA_WIDTH-1:0] ram [2**AW];
    logic signed [DATA_WIDTH-1:0] rd_q, x, a, d, ram_wd;
    logic signed [COEF_WIDTH-1:0] lo_q [MAX_FILTER_SIZE];
    logic signed [COEF_WIDTH-1:0] hi_q [MAX_FILTER_SIZE];

    assign cfg_ok   = f_q != '0 && f_q <= FW'(MAX_FILTER_SIZE) && lv_q != '0 && lv_q <= LW'(MAX_LEVELS)
                      && ln_q >= NW'(lv_q) && ln_q <= NW'(MAX_LEN_LOG2);
    assign nl       = (AW+1)'(1) << (ln_q - NW'(lvl_q));
    assign ml1      = nl[AW:1] - AW'(1);
    assign last_k   = k_q == ml1;
    assign last_lvl = lvl_q == lv_q - LW'(1);
    assign addr     = (AW+2)'({k_q, 1'b0}) + (AW+2)'(c_q);
    assign idle_wr  = state_q == S_IDLE && !go;
    assign ram_we   = (idle_wr && sample_wr_en) || state_q == S_WB;
    assign ram_wa   = state_q == S_WB ? k_q : sample_wr_addr;
    assign ram_wd   = state_q == S_WB ? a : sample_wr_data;
    assign x        = pad_q ? '0 : rd_q;

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        lvl_d = lvl_q;
        c_d = c_q;
        case (state_q)
            S_IDLE:   state_d = go ? S_CHECK : S_IDLE;
            S_CHECK: begin
                state_d = cfg_ok ? S_MAC : S_ERR;
                k_d = '0;
                lvl_d = '0;
                c_d = '0;
            end
            S_MAC: begin
                state_d = c_q == f_q ? S_EMIT_D : S_MAC;
                c_d = c_q == f_q ? '0 : c_q + FW'(1);
            end
            S_EMIT_D: state_d = !out_ready ? S_EMIT_D : last_lvl ? S_EMIT_A : S_WB;
            S_EMIT_A: state_d = !out_ready ? S_EMIT_A : last_k ? S_DONE : S_NEXT;
            S_WB:     state_d = S_NEXT;
            S_NEXT: begin
                state_d = (!last_k || !last_lvl) ? S_MAC : S_DONE;
                k_d = last_k ? '0 : k_q + AW'(1);
                lvl_d = (last_k && !last_lvl) ? lvl_q + LW'(1) : lvl_q;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q <= '0;
            lvl_q <= '0;
            c_q <= '0;
            f_q <= '0;
            lv_q <= '0;
            ln_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            lvl_q <= lvl_d;
            c_q <= c_d;
            if (state_q == S_IDLE && go) begin
                f_q <= cfg_filter_size;
                lv_q <= cfg_levels;
                ln_q <= cfg_len_log2;
                err_q <= 1'b0;
            end
            if (state_q == S_CHECK && !cfg_ok) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '{default: '0};
            hi_q <= '{default: '0};
        end else if (idle_wr && coef_wr_en) begin
            if (coef_wr_hi) hi_q[coef_wr_idx] <= coef_wr_data;
            else lo_q[coef_wr_idx] <= coef_wr_data;
        end
    end

    // Read data lands one cycle later, so padding flag and tap index travel with it.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
        rd_q <= ram[addr[AW-1:0]];
        pad_q <= addr >= (AW+2)'(nl);
        tap_q <= c_q[IW-1:0];
    end

    dwt_mac_unit #(
        .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH),
        .COEF_FRAC(COEF_FRAC), .MAX_FILTER_SIZE(MAX_FILTER_SIZE)
    ) u_mac (
        .clk(clk), .rst(rst),
        .clr_i(state_q == S_MAC && c_q == '0),
        .en_i(state_q == S_MAC && c_q != '0),
        .x_i(x), .lo_i(lo_q[tap_q]), .hi_i(hi_q[tap_q]),
        .a_o(a), .d_o(d)
    );

    assign busy       = !(state_q inside {S_IDLE, S_ERR, S_DONE});
    assign done       = state_q == S_ERR || state_q == S_DONE;
    assign err        = err_q;
    assign out_valid  = state_q == S_EMIT_D || state_q == S_EMIT_A;
    assign out_detail = state_q == S_EMIT_D;
    assign out_data   = !out_valid ? '0 : state_q == S_EMIT_A ? a : d;
    assign out_level  = out_valid ? OW'(lvl_q) : '0;
    assign out_index  = out_valid ? k_q : '0;
endmodule

// File: tb/tb_dwt_multilevel_core.sv
// tb_dwt_multilevel_core: directed vectors with hand-computed coefficients for the DWT core.
module tb_dwt_multilevel_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_wr_en = 1'b0;
    logic [10:0] sample_wr_addr = '0;
    logic [31:0] sample_wr_data = '0;
    logic        coef_wr_en = 1'b0;
    logic        coef_wr_hi = 1'b0;
    logic [4:0]  coef_wr_idx = '0;
    logic [15:0] coef_wr_data = '0;
    logic [5:0]  cfg_filter_size = '0;
    logic [2:0]  cfg_levels = '0;
    logic [3:0]  cfg_len_log2 = '0;
    logic        go = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, done, err, out_valid, out_detail;
    logic [31:0] out_data;
    logic [1:0]  out_level;
    logic [10:0] out_index;

    int n_chk = 0, n_fail = 0, cyc = 0, t_go = 0, t_done = 0, a_exp = 0;
    logic busy_done;
    logic [63:0] got[$], ex[$], snap;
    int tv[$];

    always #5 clk = ~clk;

    dwt_multilevel_core dut (
        .clk(clk), .rst(rst),
        .sample_wr_en(sample_wr_en), .sample_wr_addr(sample_wr_addr), .sample_wr_data(sample_wr_data),
        .coef_wr_en(coef_wr_en), .coef_wr_hi(coef_wr_hi), .coef_wr_idx(coef_wr_idx), .coef_wr_data(coef_wr_data),
        .cfg_filter_size(cfg_filter_size), .cfg_levels(cfg_levels), .cfg_len_log2(cfg_len_log2),
        .go(go), .busy(busy), .done(done), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_detail(out_detail), .out_level(out_level), .out_index(out_index)
    );

    function automatic logic [63:0] pk(input logic det, input int lv, input int ix, input int dt);
        return {14'd0, 1'b1, det, 4'(lv), 12'(ix), 32'(dt)};
    endfunction

    function automatic logic [63:0] cur();
        return {14'd0, out_valid, out_detail, 2'd0, out_level, 1'b0, out_index, out_data};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr_s(input int adr, input int dat);
        sample_wr_en = 1'b1;
        sample_wr_addr = 11'(adr);
        sample_wr_data = 32'(dat);
        tick();
        sample_wr_en = 1'b0;
    endtask

    task automatic wr_c(input logic hi, input int idx, input int dat);
        coef_wr_en = 1'b1;
        coef_wr_hi = hi;
        coef_wr_idx = 5'(idx);
        coef_wr_data = 16'(dat);
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic load4(input int a0, input int a1, input int a2, input int a3);
        wr_s(0, a0);
        wr_s(1, a1);
        wr_s(2, a2);
        wr_s(3, a3);
    endtask

    task automatic haar();
        wr_c(1'b0, 0, 8192);
        wr_c(1'b0, 1, 8192);
        wr_c(1'b1, 0, 8192);
        wr_c(1'b1, 1, -8192);
    endtask

    task automatic start(input int f, input int l, input int ln);
        cfg_filter_size = 6'(f);
        cfg_levels = 3'(l);
        cfg_len_log2 = 4'(ln);
        go = 1'b1;
        t_go = cyc;
        tick();
        go = 1'b0;
        sample_wr_en = 1'b0;
    endtask

    task automatic run(input int f, input int l, input int ln);
        got.delete();
        tv.delete();
        t_done = -1;
        out_ready = 1'b1;
        start(f, l, ln);
        for (int i = 0; i < 200 && t_done < 0; i++) begin
            if (out_valid) begin
                got.push_back(cur());
                tv.push_back(cyc);
            end
            if (done) begin
                t_done = cyc;
                busy_done = busy;
            end
            tick();
        end
        check("job reaches done", 64'(t_done >= 0), 64'(1));
    endtask

    task automatic cmp(input string tag);
        check({tag, " count"}, 64'(got.size()), 64'(ex.size()));
        foreach (ex[i]) check($sformatf("%s item %0d", tag, i), i < got.size() ? got[i] : '1, ex[i]);
    endtask

    initial begin
        tick();
        tick();
        check("reset flags", 64'({busy, done, err}), 64'(0));
        check("reset outputs", cur(), 64'(0));
        rst = 1'b0;
        tick();
        haar();

        load4(4, 2, 6, 8);
        run(2, 1, 2);
        ex = {pk(1, 0, 0, 1), pk(0, 0, 0, 3), pk(1, 0, 1, -1), pk(0, 0, 1, 7)};
        cmp("haar L1");
        if (tv.size() == 4) begin
            check("first d latency", 64'(tv[0] - t_go), 64'(5));
            check("pair spacing", 64'(tv[2] - tv[0]), 64'(6));
            check("done after last", 64'(t_done), 64'(tv[3] + 1));
        end
        check("busy low at done", 64'(busy_done), 64'(0));

        load4(4, 2, 6, 8);
        run(2, 2, 2);
        ex = {pk(1, 0, 0, 1), pk(1, 0, 1, -1), pk(1, 1, 0, -2), pk(0, 1, 0, 5)};
        cmp("haar L2");

        wr_c(1'b0, 2, 8192);
        wr_c(1'b0, 3, 8192);
        wr_c(1'b1, 2, 0);
        wr_c(1'b1, 3, 0);
        load4(4, 2, 6, 8);
        run(4, 1, 2);
        ex = {pk(1, 0, 0, 1), pk(0, 0, 0, 10), pk(1, 0, 1, -1), pk(0, 0, 1, 7)};
        cmp("F4 zero pad");

        load4(0, 3, 5, 0);
        run(2, 1, 2);
        ex = {pk(1, 0, 0, -2), pk(0, 0, 0, 1), pk(1, 0, 1, 2), pk(0, 0, 1, 2)};
        cmp("floor shift");

        wr_c(1'b0, 0, 16384);
        wr_c(1'b0, 1, 16384);
        wr_c(1'b1, 0, 16384);
        wr_c(1'b1, 1, -16384);
        wr_s(0, 32'h7FFFFFFF);
        wr_s(1, 32'h7FFFFFFF);
        run(2, 1, 1);
`ifdef DWT_CORE_SAT_EN
        a_exp = 32'h7FFFFFFF;
`else
        a_exp = -2;
`endif
        ex = {pk(1, 0, 0, 0), pk(0, 0, 0, a_exp)};
        cmp("overflow");
        haar();

        load4(4, 2, 6, 8);
        out_ready = 1'b0;
        start(2, 1, 2);
        for (int i = 0; i < 30 && !out_valid; i++) tick();
        snap = cur();
        check("stall first d", snap, pk(1, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall hold %0d", i), cur(), snap);
        end
        out_ready = 1'b1;
        tick();
        check("stall resume a0", cur(), pk(0, 0, 0, 3));
        for (int i = 0; i < 60 && !done; i++) tick();
        check("stall job done", 64'(done), 64'(1));
        tick();

        load4(4, 2, 6, 8);
        sample_wr_en = 1'b1;
        sample_wr_addr = 11'd0;
        sample_wr_data = 32'd100;
        run(2, 1, 2);
        check("write with go dropped", got.size() > 1 ? got[1] : '1, pk(0, 0, 0, 3));

        start(2, 3, 2);
        check("err t+1", 64'({busy, done, out_valid}), 64'(3'b100));
        tick();
        check("err t+2", 64'({busy, done, err, out_valid}), 64'(4'b0110));
        tick();
        check("err held", 64'({done, err, out_valid}), 64'(3'b010));

        start(2, 1, 2);
        check("err cleared on go", 64'({busy, err}), 64'(2'b10));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid mac flags", 64'({busy, done, err}), 64'(0));
        check("rst mid mac outputs", cur(), 64'(0));

        load4(4, 2, 6, 8);
        run(2, 1, 2);
        ex = {pk(1, 0, 0, 0), pk(0, 0, 0, 0), pk(1, 0, 1, 0), pk(0, 0, 1, 0)};
        cmp("coef reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
